astro_rom_loader: RTL and testbench
===================================

ASTRO_ROM_LOADER -- requirements
Module: astro_rom_loader

Interface
REQ-001 The module SHALL have parameter CART_AW, default 13, giving the cart/BIOS RAM address width (8 KiB).
REQ-002 The module SHALL have parameter HOLD_CYCLES, default 16, giving the clk_sys cycles of post-load system reset.
REQ-003 The module SHALL have port clk_sys, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-004 The module SHALL have port reset_l, input, 1 bit, the reset; it is synchronous and active-low.
REQ-005 The module SHALL have ports ioctl_download, input, 1 bit; ioctl_wr, input, 1 bit; ioctl_addr, input, 25 bits; ioctl_dout, input, 8 bits; ioctl_index, input, 8 bits (0 = BIOS, 1 = cart). These carry the HPS download stream.
REQ-006 The module SHALL have ports cpu_cart_addr and cpu_bios_addr, input, CART_AW bits each, carrying the BALLY fetch addresses.
REQ-007 The module SHALL have ports cart_ram_addr and bios_ram_addr, output, CART_AW bits each, driving the RAM address ports.
REQ-008 The module SHALL have ports cart_ram_we and bios_ram_we, output, 1 bit each; and ram_din, output, 8 bits.
REQ-009 The module SHALL have port sys_reset, output, 1 bit; 1 holds BALLY in reset.
REQ-010 The module SHALL have ports cart_size, output, 14 bits (bytes loaded), and cart_ovf, output, 1 bit (image exceeded 8 KiB).
REQ-011 The module SHALL have port cart_sum, output, 8 bits, present only with ASTRO_ROM_CHECKSUM_EN.

Function
REQ-012 The FSM SHALL have four states: IDLE, LOAD, PAD, HOLD.
REQ-013 From IDLE, ioctl_download=1 SHALL move the FSM to LOAD and latch ioctl_index. On entry with index 1, cart_size, cart_ovf and cart_sum SHALL clear.
REQ-014 In LOAD, each ioctl_wr=1 cycle with ioctl_addr < 2^CART_AW SHALL issue exactly one write in the same cycle: RAM address = ioctl_addr[CART_AW-1:0], the we of the latched target asserted, ram_din = ioctl_dout.
REQ-015 In LOAD, a write with ioctl_addr >= 2^CART_AW SHALL be dropped, SHALL set cart_ovf, and SHALL leave cart_size unchanged.
REQ-016 For index 1, cart_size SHALL become max(cart_size, ioctl_addr+1) on each accepted write, saturating at 2^CART_AW.
REQ-017 Indices other than 0 and 1 SHALL produce no writes; the FSM still sequences through LOAD to HOLD.
REQ-018 On ioctl_download falling, LOAD SHALL go to PAD if the index is 1 and cart_size < 2^CART_AW; otherwise it SHALL go to HOLD. An ioctl_wr in that same cycle SHALL still be written.
REQ-019 PAD SHALL write 8'hFF to cart addresses cart_size .. 2^CART_AW-1, one per cycle, ascending. It SHALL go to HOLD the cycle after the last write. cart_size SHALL NOT change during PAD.
REQ-020 HOLD SHALL count HOLD_CYCLES cycles and then go to IDLE.
REQ-021 A rising ioctl_download while in PAD or HOLD SHALL abandon the current state and re-enter LOAD.
REQ-022 sys_reset SHALL be 1 in LOAD, PAD and HOLD and 0 in IDLE, registered so that it is asserted one cycle after the state is entered.
REQ-023 In IDLE, the RAM addresses SHALL pass cpu_cart_addr and cpu_bios_addr through combinationally, and both we SHALL be 0.
REQ-024 In LOAD, PAD and HOLD, the RAM address of a non-written RAM SHALL be don't-care.

Reset
REQ-025 While reset_l=0 at a clock edge, the FSM SHALL go to IDLE with cart_size=0, cart_ovf=0, cart_sum=0, both we=0 and sys_reset=1.
REQ-026 On the first edge after release, sys_reset SHALL fall, unless ioctl_download=1 at that edge.
REQ-027 Reset mid-LOAD or mid-PAD SHALL abort with no further writes.

Configuration
REQ-028 With ASTRO_ROM_CHECKSUM_EN defined, cart_sum SHALL accumulate the modulo-256 sum of ioctl_dout over accepted index-1 writes; PAD bytes SHALL NOT be counted.
REQ-029 Without ASTRO_ROM_CHECKSUM_EN, the cart_sum port and its adder SHALL be absent.

Structure
REQ-030 Package astro_pkg SHALL hold the FSM state enum, IDX_BIOS=0, IDX_CART=1 and PAD_BYTE=8'hFF.
REQ-031 The module SHALL contain one sub-module, astro_hold_timer, a loadable down-counter for HOLD; all other logic is inline.

Verification
REQ-032 Reset, then download a 4 KiB cart (index 1, bytes = addr[7:0]) -> cart_size=4096; 4096 PAD writes of FF at 4096..8191; sys_reset high until 16 cycles after PAD ends.
REQ-033 Download a 9000-byte cart -> writes at addr 0..8191 only; cart_ovf=1; cart_size=8192; no PAD.
REQ-034 Download 8 KiB to index 0 -> only bios_ram_we pulses (8192); cart_size unchanged; HOLD follows directly.
REQ-035 Assert reset_l=0 mid-PAD at addr 5000 -> no writes after that edge; state IDLE; cart_size=0.
REQ-036 Re-assert ioctl_download during HOLD cycle 5 -> LOAD re-entered next cycle; sys_reset stays 1 throughout.
REQ-037 With ASTRO_ROM_CHECKSUM_EN, load 3 bytes 0x80, 0x90, 0x01 -> cart_sum=0x11, unchanged after PAD.

Source files
------------

// File: rtl/astro_pkg.sv
// Shared types and constants for the Astrocade ROM loader.
package astro_pkg;

   // Loader sequencing: wait, stream bytes in, fill the cart tail, hold BALLY in reset.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_PAD  = 2'd2,
      ST_HOLD = 2'd3
   } astro_state_e;

   localparam logic [7:0] IDX_BIOS = 8'd0;
   localparam logic [7:0] IDX_CART = 8'd1;
   localparam logic [7:0] PAD_BYTE = 8'hFF;

endpackage

// File: rtl/astro_hold_timer.sv
// Loadable down-counter that times the post-load reset hold.
// zero_o is high once the count has reached zero; dec_i stops at zero.
module astro_hold_timer #(
   parameter int unsigned CW = 4
) (
   input  logic          clk_i,
   input  logic          reset_l_i,
   input  logic          load_i,
   input  logic [CW-1:0] load_val_i,
   input  logic          dec_i,
   output logic          zero_o
);

   logic [CW-1:0] cnt_q, cnt_d;

   // Next count: a load wins over a decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!reset_l_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/astro_rom_loader.sv
// Astrocade BIOS/cart loader: routes the HPS download stream into the BIOS or
// cart RAM, pads short carts with FF, then holds BALLY in reset briefly.
// Optional feature macro: ASTRO_ROM_CHECKSUM_EN adds the cart_sum output.
module astro_rom_loader
   import astro_pkg::*;
#(
   parameter int CART_AW     = 13,
   parameter int HOLD_CYCLES = 16
) (
   input  logic               clk_sys,
   input  logic               reset_l,
   input  logic               ioctl_download,
   input  logic               ioctl_wr,
   input  logic [24:0]        ioctl_addr,
   input  logic [7:0]         ioctl_dout,
   input  logic [7:0]         ioctl_index,
   input  logic [CART_AW-1:0] cpu_cart_addr,
   input  logic [CART_AW-1:0] cpu_bios_addr,
   output logic [CART_AW-1:0] cart_ram_addr,
   output logic [CART_AW-1:0] bios_ram_addr,
   output logic               cart_ram_we,
   output logic               bios_ram_we,
   output logic [7:0]         ram_din,
   output logic               sys_reset,
   output logic [13:0]        cart_size,
   output logic               cart_ovf,
   output astro_state_e       dbg_state_o
`ifdef ASTRO_ROM_CHECKSUM_EN
   ,
   output logic [7:0]         cart_sum
`endif
);

   // Handshake: ioctl_wr is a one-cycle valid qualifying ioctl_addr/ioctl_dout.
   // There is no ready; every valid seen in LOAD is consumed in that same cycle,
   // either written to RAM or dropped as out of range.

   localparam int SW = CART_AW + 1;
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [SW-1:0] SIZE_FULL = SW'(1) << CART_AW;
   localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

   astro_state_e       state_q, state_d;
   logic [7:0]         idx_q, idx_d;
   logic [SW-1:0]      size_q, size_d;
   logic               ovf_q, ovf_d;
   logic [CART_AW-1:0] pad_q, pad_d;
   logic               sys_reset_q;
   logic               dl_q;

   logic               in_range;
   logic [SW-1:0]      wr_end;
   logic               dl_rise;
   logic               enter_load;
   logic               cart_we;
   logic               bios_we;
   logic               hold_load;
   logic               hold_dec;
   logic               hold_zero;

   assign in_range = (ioctl_addr[24:CART_AW] == '0);
   assign wr_end   = {1'b0, ioctl_addr[CART_AW-1:0]} + SW'(1);
   assign dl_rise  = ioctl_download & ~dl_q;

   // Next-state, RAM port muxing and size/overflow tracking.
   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      size_d        = size_q;
      ovf_d         = ovf_q;
      pad_d         = pad_q;
      cart_we       = 1'b0;
      bios_we       = 1'b0;
      cart_ram_addr = cpu_cart_addr;
      bios_ram_addr = cpu_bios_addr;
      ram_din       = ioctl_dout;
      hold_load     = 1'b0;
      hold_dec      = 1'b0;
      enter_load    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (ioctl_download) begin
               enter_load = 1'b1;
            end
         end
         ST_LOAD: begin
            cart_ram_addr = ioctl_addr[CART_AW-1:0];
            bios_ram_addr = ioctl_addr[CART_AW-1:0];
            if (ioctl_wr) begin
               if (in_range) begin
                  if (idx_q == IDX_BIOS) begin
                     bios_we = 1'b1;
                  end else if (idx_q == IDX_CART) begin
                     cart_we = 1'b1;
                     if (wr_end > size_q) begin
                        size_d = wr_end;
                     end
                  end
               end else begin
                  ovf_d = 1'b1;
               end
            end
            // The size decision includes a write landing in the falling cycle.
            if (!ioctl_download) begin
               pad_d = size_d[CART_AW-1:0];
               if ((idx_q == IDX_CART) && (size_d < SIZE_FULL)) begin
                  state_d = ST_PAD;
               end else begin
                  state_d   = ST_HOLD;
                  hold_load = 1'b1;
               end
            end
         end
         ST_PAD: begin
            if (dl_rise) begin
               enter_load = 1'b1;
            end else begin
               cart_we       = 1'b1;
               cart_ram_addr = pad_q;
               ram_din       = PAD_BYTE;
               if (pad_q == '1) begin
                  state_d   = ST_HOLD;
                  hold_load = 1'b1;
               end else begin
                  pad_d = pad_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (dl_rise) begin
               enter_load = 1'b1;
            end else if (hold_zero) begin
               state_d = ST_IDLE;
            end else begin
               hold_dec = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // A new download latches its target; a cart download starts from scratch.
      if (enter_load) begin
         state_d = ST_LOAD;
         idx_d   = ioctl_index;
         if (ioctl_index == IDX_CART) begin
            size_d = '0;
            ovf_d  = 1'b0;
         end
      end
   end

   // State and bookkeeping registers. sys_reset follows the next state so it
   // drops on the first edge after reset release unless a download starts.
   always_ff @(posedge clk_sys) begin
      if (!reset_l) begin
         state_q     <= ST_IDLE;
         idx_q       <= IDX_BIOS;
         size_q      <= '0;
         ovf_q       <= 1'b0;
         pad_q       <= '0;
         sys_reset_q <= 1'b1;
         dl_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         size_q      <= size_d;
         ovf_q       <= ovf_d;
         pad_q       <= pad_d;
         sys_reset_q <= (state_d != ST_IDLE);
         dl_q        <= ioctl_download;
      end
   end

   astro_hold_timer #(
      .CW (HW)
   ) u_hold_timer (
      .clk_i      (clk_sys),
      .reset_l_i  (reset_l),
      .load_i     (hold_load),
      .load_val_i (HOLD_LOAD),
      .dec_i      (hold_dec),
      .zero_o     (hold_zero)
   );

   // Write enables are blocked while reset is asserted so an abort is clean.
   assign cart_ram_we = cart_we & reset_l;
   assign bios_ram_we = bios_we & reset_l;
   assign sys_reset   = sys_reset_q;
   assign cart_size   = 14'(size_q);
   assign cart_ovf    = ovf_q;
   assign dbg_state_o = state_q;

`ifdef ASTRO_ROM_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;

   // Running mod-256 sum of accepted cart bytes; pad bytes never count.
   always_comb begin
      sum_d = sum_q;
      if (enter_load && (ioctl_index == IDX_CART)) begin
         sum_d = '0;
      end else if ((state_q == ST_LOAD) && ioctl_wr && in_range && (idx_q == IDX_CART)) begin
         sum_d = sum_q + ioctl_dout;
      end
   end

   // Checksum register.
   always_ff @(posedge clk_sys) begin
      if (!reset_l) begin
         sum_q <= '0;
      end else begin
         sum_q <= sum_d;
      end
   end

   assign cart_sum = sum_q;
`endif

endmodule

// File: tb/tb_astro_rom_loader.sv
// Bench for astro_rom_loader: random downloads against a queue-based model.
module tb_astro_rom_loader;
  import astro_pkg::*;

  localparam int NB   = 8192;
  localparam int HOLD = 16;

  logic         clk_sys = 1'b0;
  logic         reset_l;
  logic         ioctl_download;
  logic         ioctl_wr;
  logic [24:0]  ioctl_addr;
  logic [7:0]   ioctl_dout;
  logic [7:0]   ioctl_index;
  logic [12:0]  cpu_cart_addr;
  logic [12:0]  cpu_bios_addr;
  logic [12:0]  cart_ram_addr;
  logic [12:0]  bios_ram_addr;
  logic         cart_ram_we;
  logic         bios_ram_we;
  logic [7:0]   ram_din;
  logic         sys_reset;
  logic [13:0]  cart_size;
  logic         cart_ovf;
  astro_state_e dbg_state;
`ifdef ASTRO_ROM_CHECKSUM_EN
  logic [7:0]   cart_sum;
`endif

  astro_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset_l        (reset_l),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_index    (ioctl_index),
    .cpu_cart_addr  (cpu_cart_addr),
    .cpu_bios_addr  (cpu_bios_addr),
    .cart_ram_addr  (cart_ram_addr),
    .bios_ram_addr  (bios_ram_addr),
    .cart_ram_we    (cart_ram_we),
    .bios_ram_we    (bios_ram_we),
    .ram_din        (ram_din),
    .sys_reset      (sys_reset),
    .cart_size      (cart_size),
    .cart_ovf       (cart_ovf),
    .dbg_state_o    (dbg_state)
`ifdef ASTRO_ROM_CHECKSUM_EN
    ,
    .cart_sum       (cart_sum)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk_sys = ~clk_sys;

  // ---------------- scoreboard state ----------------
  // entry = {is_bios, addr[12:0], data[7:0]}
  logic [21:0] exp_q[$];
  int n_chk  = 0;
  int n_pass = 0;

  // reference model of the loader's visible registers
  int           m_idx  = 0;
  int           m_size = 0;
  bit           m_ovf  = 1'b0;
  logic [7:0]   m_sum  = 8'h00;
  astro_state_e m_next = ST_IDLE;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // ---------------- monitor ----------------
  logic [21:0] mon_act;
  logic [21:0] mon_exp;
  always @(negedge clk_sys) begin
    if (cart_ram_we || bios_ram_we) begin
      if (cart_ram_we && bios_ram_we) check("we_exclusive", 1, 0);
      mon_act = bios_ram_we ? {1'b1, bios_ram_addr, ram_din} : {1'b0, cart_ram_addr, ram_din};
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_write: got 0x%0h expected no write", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("ram_write", mon_act, mon_exp);
      end
    end
  end

  // ---------------- model ----------------
  task automatic model_start(input int idx);
    m_idx = idx;
    if (idx == 1) begin
      m_size = 0;
      m_ovf  = 1'b0;
      m_sum  = 8'h00;
    end
  endtask

  task automatic model_write(input int a, input logic [7:0] d);
    if (a >= NB) m_ovf = 1'b1;
    else if (m_idx == 0) exp_q.push_back({1'b1, 13'(a), d});
    else if (m_idx == 1) begin
      exp_q.push_back({1'b0, 13'(a), d});
      if (a + 1 > m_size) m_size = a + 1;
      m_sum = m_sum + d;
    end
  endtask

  task automatic model_end();
    if (m_idx == 1 && m_size < NB) begin
      for (int p = m_size; p < NB; p++) exp_q.push_back({1'b0, 13'(p), 8'hFF});
      m_next = ST_PAD;
    end else begin
      m_next = ST_HOLD;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input int idx);
    tick();
    ioctl_download = 1'b1;
    ioctl_index    = 8'(idx);
    model_start(idx);
  endtask

  task automatic wr_byte(input int a, input logic [7:0] d, input bit fall);
    tick();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    model_write(a, d);
    if (fall) begin
      ioctl_download = 1'b0;
      model_end();
    end
  endtask

  task automatic end_dl();
    tick();
    ioctl_download = 1'b0;
    model_end();
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_size"}, cart_size, m_size);
    check({tag, "_ovf"}, cart_ovf, m_ovf);
`ifdef ASTRO_ROM_CHECKSUM_EN
    check({tag, "_sum"}, cart_sum, m_sum);
`endif
  endtask

  // Called in the first cycle after LOAD ends; runs through PAD and HOLD.
  task automatic finish_phase(input string tag);
    int n;
    int exp_pad;
    bit bad;
    exp_pad = (m_next == ST_PAD) ? (NB - m_size) : 0;
    bad = 1'b0;
    check({tag, "_next_state"}, int'(dbg_state), int'(m_next));
    n = 0;
    while (dbg_state == ST_PAD && n < NB + 10) begin
      if (!sys_reset) bad = 1'b1;
      tick();
      n++;
    end
    check({tag, "_pad_len"}, n, exp_pad);
    n = 0;
    while (dbg_state == ST_HOLD && n < HOLD + 10) begin
      if (!sys_reset) bad = 1'b1;
      tick();
      n++;
    end
    check({tag, "_hold_len"}, n, HOLD);
    check({tag, "_sysreset_held"}, bad, 0);
    check({tag, "_idle"}, int'(dbg_state), int'(ST_IDLE));
    check({tag, "_sysreset_low"}, sys_reset, 0);
    check({tag, "_sb_drain"}, exp_q.size(), 0);
    check_regs({tag, "_post"});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit bad;
    reset_l        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    ioctl_index    = '0;
    cpu_cart_addr  = '0;
    cpu_bios_addr  = '0;
    repeat (3) tick();

    // reset state
    check("rst_state", int'(dbg_state), int'(ST_IDLE));
    check("rst_sysreset", sys_reset, 1);
    check("rst_size", cart_size, 0);
    check("rst_ovf", cart_ovf, 0);
    check("rst_we", {cart_ram_we, bios_ram_we}, 0);
`ifdef ASTRO_ROM_CHECKSUM_EN
    check("rst_sum", cart_sum, 0);
`endif
    reset_l = 1'b1;
    tick();
    check("rel_sysreset", sys_reset, 0);

    // idle pass-through of CPU fetch addresses
    for (int i = 0; i < 4; i++) begin
      cpu_cart_addr = 13'($urandom_range(0, NB - 1));
      cpu_bios_addr = 13'($urandom_range(0, NB - 1));
      #1;
      check("idle_cart_addr", cart_ram_addr, cpu_cart_addr);
      check("idle_bios_addr", bios_ram_addr, cpu_bios_addr);
      check("idle_we", {cart_ram_we, bios_ram_we}, 0);
      tick();
    end

    // A: 4 KiB cart, data = addr[7:0], then pad 4096..8191
    start_dl(1);
    for (int a = 0; a < 4096; a++) wr_byte(a, 8'(a), 1'b0);
    end_dl();
    tick();
    check_regs("A");
    finish_phase("A");

    // B: random-order cart writes with idle gaps; last write lands with the fall
    start_dl(1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) tick();
      wr_byte($urandom_range(0, 1999), 8'($urandom_range(0, 255)), k == 299);
    end
    tick();
    check_regs("B");
    finish_phase("B");

    // C: 9000-byte cart overflows; no pad
    start_dl(1);
    for (int a = 0; a < 9000; a++) wr_byte(a, 8'($urandom_range(0, 255)), 1'b0);
    end_dl();
    tick();
    check_regs("C");
    finish_phase("C");

    // D: 8 KiB BIOS, straight to HOLD, then re-download in HOLD cycle 5
    start_dl(0);
    for (int a = 0; a < NB; a++) wr_byte(a, 8'($urandom_range(0, 255)), 1'b0);
    end_dl();
    tick();
    check("D_state_hold", int'(dbg_state), int'(ST_HOLD));
    check_regs("D");
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!sys_reset) bad = 1'b1;
      tick();
    end
    check("D_hold5_state", int'(dbg_state), int'(ST_HOLD));
    if (!sys_reset) bad = 1'b1;
    ioctl_download = 1'b1;
    ioctl_index    = 8'd2;
    model_start(2);
    tick();
    check("D_reenter_load", int'(dbg_state), int'(ST_LOAD));
    check("D_reenter_sysreset", sys_reset, 1);
    for (int i = 0; i < 3; i++) wr_byte(i * 7, 8'($urandom_range(0, 255)), 1'b0);
    end_dl();
    tick();
    check("D_sysreset_through", bad, 0);
    finish_phase("D2");

    // E: three-byte cart for the checksum
    start_dl(1);
    wr_byte(0, 8'h80, 1'b0);
    wr_byte(1, 8'h90, 1'b0);
    wr_byte(2, 8'h01, 1'b0);
    end_dl();
    tick();
    check_regs("E");
    finish_phase("E");

    // F: reset while padding address 5000
    start_dl(1);
    for (int a = 0; a < 3000; a++) wr_byte(a, 8'($urandom_range(0, 255)), 1'b0);
    end_dl();
    tick();
    check("F_state_pad", int'(dbg_state), int'(ST_PAD));
    n = 0;
    while (!(cart_ram_we && cart_ram_addr == 13'd5000) && n < 3000) begin
      tick();
      n++;
    end
    check("F_reach_5000", n, 2000);
    @(negedge clk_sys);
    #1;
    reset_l        = 1'b0;
    ioctl_download = 1'b0;
    @(posedge clk_sys);
    #1;
    check("F_rst_state", int'(dbg_state), int'(ST_IDLE));
    check("F_rst_size", cart_size, 0);
    check("F_rst_ovf", cart_ovf, 0);
    check("F_rst_sysreset", sys_reset, 1);
    check("F_rst_we", {cart_ram_we, bios_ram_we}, 0);
    check("F_pending", exp_q.size(), NB - 1 - 5000);
    exp_q.delete();
    m_size = 0;
    m_ovf  = 1'b0;
    m_sum  = 8'h00;
    tick();
    reset_l = 1'b1;
    tick();
    check("F_rel_sysreset", sys_reset, 0);
    check("F_rel_state", int'(dbg_state), int'(ST_IDLE));
    check_regs("F");
    repeat (4) tick();

    check("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
